usb_rx_ctrl: RTL and testbench
==============================

# usb_rx_ctrl

Packet-level sequencer for the USB receive path. Sits above the bit timer and NRZI decoder, consumes the per-bit `en_sample` strobe, and does the following:

- resynchronises the bit timer at packet start;
- validates the SYNC field;
- strips stuffed bits;
- assembles bytes LSB-first and writes them into the RX FIFO;
- checks the end-of-packet (EOP) sequence.

It reports `rcving` and a sticky `r_error` to the protocol layer.

## Interface
Parameters:
- SYNC_BYTE, 8'h80, expected SYNC field after LSB-first assembly
- STUFF_LEN, 6, consecutive 1s after which one stuffed 0 is mandatory

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- d_edge  in  1  bus transition detected (packet start when idle)
- en_sample  in  1  one-cycle bit strobe from bit timer; consecutive strobes ≥8 clk apart
- d_orig  in  1  NRZI-decoded bit, valid when en_sample=1
- eop  in  1  SE0 on bus, valid when en_sample=1
- fifo_full  in  1  RX FIFO cannot accept a write
- timer_clear  out  1  one-cycle pulse that restarts the bit timer phase
- rcving  out  1  packet reception in progress
- r_error  out  1  sticky packet error
- w_enable  out  1  one-cycle FIFO write strobe
- rx_data  out  8  last completed byte

## Operation
- Registers:
  - `shreg[7:0]`: shifts LSB-first, `shreg <= {d_orig, shreg[7:1]}`
  - `bit_cnt[3:0]`
  - `ones_cnt[2:0]`: saturates at STUFF_LEN
  - `rx_data`
  - `r_error`
  - state
- IDLE:
  - `rcving`=0.
  - On d_edge: `timer_clear`=1 (combinational, same cycle), clear `r_error`, `bit_cnt`=0, `ones_cnt`=0, go to SYNC.
- SYNC:
  - Each en_sample with eop=0: shift, `bit_cnt`++, update `ones_cnt` (d_orig ? +1 : 0).
  - On the 8th bit: if the resulting byte equals SYNC_BYTE, go to RECEIVE with `bit_cnt`=0 and `ones_cnt` carried over. Otherwise go to ERR_WAIT.
  - en_sample with eop=1 → ERR_EOP.
- RECEIVE, on each en_sample:
  - eop=1 with `bit_cnt`==0 → EOP2.
  - eop=1 with `bit_cnt`≠0 → ERR_EOP (partial byte).
  - `ones_cnt`==STUFF_LEN:
    - d_orig=0 → discard the bit, `ones_cnt`=0, `bit_cnt` unchanged.
    - d_orig=1 → ERR_WAIT (stuff violation).
  - Otherwise: shift, `bit_cnt`++, update `ones_cnt`.
  - When `bit_cnt` reaches 8: load `rx_data` with the completed byte on the same edge, `bit_cnt`=0, go to WRITE.
- WRITE (exactly 1 cycle):
  - fifo_full=0 → `w_enable`=1, return to RECEIVE.
  - fifo_full=1 → no write, go to ERR_WAIT (overflow).
- EOP2:
  - en_sample with eop=1 → EOP_J.
  - en_sample with eop=0 → ERR_WAIT.
- EOP_J:
  - en_sample with eop=0 (J) → IDLE (clean end).
  - en_sample with eop=1 → ERR_WAIT.
- ERR_WAIT: en_sample with eop=1 → ERR_EOP.
- ERR_EOP: en_sample with eop=0 → IDLE.
- `r_error` is set on any transition into ERR_WAIT or ERR_EOP. It holds through IDLE and clears only when the next packet start leaves IDLE.
- `rcving`=1 in every state except IDLE.
- d_edge is ignored outside IDLE.
- en_sample and eop are ignored in IDLE.

## Timing
- Reset values: state=IDLE; all outputs 0; `rx_data`=8'h00; `shreg`, `bit_cnt`, `ones_cnt` all 0.
- `rst` asserted mid-packet aborts immediately:
  - `w_enable` deasserts asynchronously.
  - No partial byte is written.
  - `r_error` is not set.
- `timer_clear` is high in the same cycle d_edge is seen in IDLE.
- `rcving` rises on the next edge.
- `w_enable` is high in the cycle immediately after the en_sample that completes a byte.
- `rx_data` is stable from that cycle until the next completed byte.
- `rcving` falls on the edge following the final J en_sample, or the J en_sample that ends an error packet.
- The WRITE cycle never coincides with en_sample, because of the ≥8 clk strobe spacing.

## Test plan
- Clean packet:
  - Stimulus: d_edge; SYNC bits 0,0,0,0,0,0,0,1; byte bits 1,0,1,0,0,1,0,1; eop,eop; J.
  - Required: one `w_enable` pulse with `rx_data`=8'hA5; `r_error`=0; `rcving` 1→0 after J.
- Bit stuffing:
  - Stimulus: after SYNC, send 1×5, stuffed 0, 1×3, then EOP.
  - Required: `rx_data`=8'hFF, single write, no error.
- Stuff violation:
  - Stimulus: after SYNC, send 1×5 then 1.
  - Required: no write; `r_error`=1 held until EOP and J; back to IDLE; cleared by the next d_edge.
- Bad SYNC:
  - Stimulus: SYNC bits assembling to 8'h81.
  - Required: `r_error`=1, no `w_enable` for the whole packet.
- Overflow and partial-byte EOP:
  - Stimulus (overflow): fifo_full=1 when byte 8'h3C completes.
  - Required: `w_enable` stays 0, `rx_data`=8'h3C, `r_error`=1.
  - Stimulus (partial byte): eop after 3 data bits.
  - Required: ERR_EOP path, `r_error`=1.
- Reset mid-byte:
  - Stimulus: `rst` pulse after 4 data bits.
  - Required: all outputs 0; the next clean packet is received correctly.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_ctrl
//  Description : USB receive packet sequencer. Resynchronises the bit timer
//                at packet start, validates SYNC, strips stuffed bits,
//                assembles LSB-first bytes into the RX FIFO and checks the
//                SE0-SE0-J end-of-packet sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'h80,
   parameter int         STUFF_LEN = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_edge,
   input  logic       en_sample,
   input  logic       d_orig,
   input  logic       eop,
   input  logic       fifo_full,
   output logic       timer_clear,
   output logic       rcving,
   output logic       r_error,
   output logic       w_enable,
   output logic [7:0] rx_data
);

   // Run length of 1s after which a stuffed 0 must follow (fits ones_cnt).
   localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SYNC     = 3'd1,
      S_RECEIVE  = 3'd2,
      S_WRITE    = 3'd3,
      S_EOP2     = 3'd4,
      S_EOP_J    = 3'd5,
      S_ERR_WAIT = 3'd6,
      S_ERR_EOP  = 3'd7
   } state_t;

   state_t     state;
   logic [7:0] shreg;
   logic [3:0] bit_cnt;
   logic [2:0] ones_cnt;

   logic [7:0] shifted;
   logic [2:0] ones_nxt;
   logic       byte_done;

   // Byte as it would look after accepting the current bit (LSB-first).
   assign shifted   = {d_orig, shreg[7:1]};
   // Run-length of 1s including the current bit, saturating at the stuff limit.
   assign ones_nxt  = !d_orig                 ? 3'd0 :
                      (ones_cnt == STUFF_MAX) ? ones_cnt :
                                                ones_cnt + 3'd1;
   // The bit being accepted now is the eighth of the byte.
   assign byte_done = (bit_cnt == 4'd7);

   // Timer restart must hit the same cycle the packet-start edge is seen.
   assign timer_clear = (state == S_IDLE) && d_edge;
   assign rcving      = (state != S_IDLE);
   // Decoded from the state flop so a reset mid-write drops it immediately.
   assign w_enable    = (state == S_WRITE) && !fifo_full;

   // Packet sequencer: state, shift register, counters, data and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         shreg    <= 8'h00;
         bit_cnt  <= 4'd0;
         ones_cnt <= 3'd0;
         rx_data  <= 8'h00;
         r_error  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (d_edge) begin
                  r_error  <= 1'b0;
                  bit_cnt  <= 4'd0;
                  ones_cnt <= 3'd0;
                  state    <= S_SYNC;
               end
            end

            S_SYNC: begin
               if (en_sample) begin
                  if (eop) begin
                     r_error <= 1'b1;
                     state   <= S_ERR_EOP;
                  end else begin
                     shreg    <= shifted;
                     ones_cnt <= ones_nxt;
                     if (byte_done) begin
                        bit_cnt <= 4'd0;
                        if (shifted == SYNC_BYTE) begin
                           state <= S_RECEIVE;
                        end else begin
                           r_error <= 1'b1;
                           state   <= S_ERR_WAIT;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
            end

            S_RECEIVE: begin
               if (en_sample) begin
                  if (eop) begin
                     // EOP is only legal on a byte boundary.
                     if (bit_cnt == 4'd0) begin
                        state <= S_EOP2;
                     end else begin
                        r_error <= 1'b1;
                        state   <= S_ERR_EOP;
                     end
                  end else if (ones_cnt == STUFF_MAX) begin
                     // This bit must be the stuffed 0; drop it from the data.
                     if (d_orig) begin
                        r_error <= 1'b1;
                        state   <= S_ERR_WAIT;
                     end else begin
                        ones_cnt <= 3'd0;
                     end
                  end else begin
                     shreg    <= shifted;
                     ones_cnt <= ones_nxt;
                     if (byte_done) begin
                        rx_data <= shifted;
                        bit_cnt <= 4'd0;
                        state   <= S_WRITE;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
            end

            S_WRITE: begin
               // Single cycle; strobe spacing guarantees no en_sample here.
               if (fifo_full) begin
                  r_error <= 1'b1;
                  state   <= S_ERR_WAIT;
               end else begin
                  state <= S_RECEIVE;
               end
            end

            S_EOP2: begin
               if (en_sample) begin
                  if (eop) begin
                     state <= S_EOP_J;
                  end else begin
                     r_error <= 1'b1;
                     state   <= S_ERR_WAIT;
                  end
               end
            end

            S_EOP_J: begin
               if (en_sample) begin
                  if (eop) begin
                     r_error <= 1'b1;
                     state   <= S_ERR_WAIT;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end

            S_ERR_WAIT: begin
               if (en_sample && eop) begin
                  r_error <= 1'b1;
                  state   <= S_ERR_EOP;
               end
            end

            S_ERR_EOP: begin
               if (en_sample && !eop) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_rx_ctrl
//  Description : Scoreboard bench for usb_rx_ctrl. Packets are built from
//                random bytes and stuffed by the bench; expected FIFO writes
//                are queued at stimulus time and popped by a write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_ctrl;

   localparam int STUFF = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d_edge = 1'b0;
   logic       en_sample = 1'b0;
   logic       d_orig = 1'b0;
   logic       eop = 1'b0;
   logic       fifo_full = 1'b0;
   logic       timer_clear;
   logic       rcving;
   logic       r_error;
   logic       w_enable;
   logic [7:0] rx_data;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_byte = 8'h00;
   int         run = 0;
   bit         in_pkt = 1'b0;

   always #5 clk = ~clk;

   usb_rx_ctrl #(.SYNC_BYTE(8'h80), .STUFF_LEN(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .d_edge     (d_edge),
      .en_sample  (en_sample),
      .d_orig     (d_orig),
      .eop        (eop),
      .fifo_full  (fifo_full),
      .timer_clear(timer_clear),
      .rcving     (rcving),
      .r_error    (r_error),
      .w_enable   (w_enable),
      .rx_data    (rx_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write monitor: every FIFO strobe must match the oldest expected byte.
   always @(negedge clk) begin
      if (!rst && w_enable) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: rx_data %0h written, no write expected (t=%0t)", rx_data, $time);
         end else begin
            check("write_data", 32'(rx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // One bit strobe followed by a random gap keeping strobes >= 8 clk apart.
   task automatic send_bit(input logic d, input logic e);
      int gap;
      @(posedge clk); #1;
      en_sample = 1'b1; d_orig = d; eop = e;
      @(posedge clk); #1;
      en_sample = 1'b0; d_orig = 1'b0; eop = 1'b0;
      gap = $urandom_range(10, 7);
      for (int i = 0; i < gap; i++) begin
         if (in_pkt && i == 2 && $urandom_range(7, 0) == 0) begin
            d_edge = 1'b1; #1;
            check("timer_clear_ignored", 32'(timer_clear), 32'd0);
         end
         @(posedge clk); #1;
         d_edge = 1'b0;
      end
   endtask

   // Data bit with the stuffing rule: a 0 is inserted after STUFF ones.
   task automatic emit_data_bit(input logic b);
      send_bit(b, 1'b0);
      run = b ? run + 1 : 0;
      if (run == STUFF) begin
         send_bit(1'b0, 1'b0);
         run = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) emit_data_bit(v[i]);
   endtask

   task automatic send_sync(input logic [7:0] s);
      run = 0;
      for (int i = 0; i < 8; i++) begin
         send_bit(s[i], 1'b0);
         run = s[i] ? run + 1 : 0;
      end
   endtask

   task automatic start_packet();
      @(posedge clk); #1;
      d_edge = 1'b1; #1;
      check("timer_clear", 32'(timer_clear), 32'd1);
      @(posedge clk); #1;
      d_edge = 1'b0;
      check("rcving_rise", 32'(rcving), 32'd1);
      check("r_error_cleared", 32'(r_error), 32'd0);
      in_pkt = 1'b1;
   endtask

   // SE0, SE0, J, then the end-of-packet state of every output.
   task automatic finish_packet(input bit err);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      in_pkt = 1'b0;
      send_bit(1'b0, 1'b0);
      check("rcving_fall", 32'(rcving), 32'd0);
      check("r_error_end", 32'(r_error), 32'(err));
      check("rx_data_end", 32'(rx_data), 32'(last_byte));
      check("writes_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      // Strobes while idle are ignored and the error flag holds.
      send_bit(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      check("idle_ignores_strobe", 32'(rcving), 32'd0);
      check("r_error_holds", 32'(r_error), 32'(err));
   endtask

   // kind: 0 clean, 1 bad sync, 2 stuff violation, 3 partial byte, 4 overflow
   task automatic run_packet(input int kind, input int nbytes);
      logic [7:0] b;
      logic [7:0] s;
      bit         err;
      int         ovf;
      int         n;
      start_packet();
      if (kind == 1) begin
         s = 8'h80 ^ 8'($urandom_range(255, 1));
         send_sync(s);
         err = 1'b1;
      end else begin
         send_sync(8'h80);
         err = (kind != 0);
         ovf = (kind == 4) ? $urandom_range(nbytes - 1, 0) : -1;
         for (int k = 0; k < nbytes; k++) begin
            b = 8'($urandom);
            if (k == ovf) begin
               fifo_full = 1'b1;
               send_byte(b);
               fifo_full = 1'b0;
               last_byte = b;
               break;
            end
            exp_q.push_back(b);
            send_byte(b);
            last_byte = b;
         end
         if (kind == 2) begin
            while (run < STUFF) begin
               send_bit(1'b1, 1'b0);
               run++;
            end
            send_bit(1'b1, 1'b0);
         end else if (kind == 3) begin
            n = $urandom_range(7, 1);
            for (int i = 0; i < n; i++) emit_data_bit(1'($urandom_range(1, 0)));
         end
      end
      finish_packet(err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_timer_clear", 32'(timer_clear), 32'd0);
      check("reset_rcving", 32'(rcving), 32'd0);
      check("reset_r_error", 32'(r_error), 32'd0);
      check("reset_w_enable", 32'(w_enable), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      rst = 1'b0;

      // Clean packet carrying 8'hA5.
      start_packet();
      send_sync(8'h80);
      exp_q.push_back(8'hA5);
      send_byte(8'hA5);
      last_byte = 8'hA5;
      finish_packet(1'b0);

      // 8'hFF forces a stuffed 0 after SYNC's trailing 1 plus five data 1s.
      start_packet();
      send_sync(8'h80);
      exp_q.push_back(8'hFF);
      send_byte(8'hFF);
      last_byte = 8'hFF;
      finish_packet(1'b0);

      // Stuff violation straight after SYNC.
      run_packet(2, 0);

      // SYNC assembling to 8'h81.
      start_packet();
      send_sync(8'h81);
      finish_packet(1'b1);

      // Overflow on 8'h3C.
      start_packet();
      send_sync(8'h80);
      fifo_full = 1'b1;
      send_byte(8'h3C);
      fifo_full = 1'b0;
      last_byte = 8'h3C;
      finish_packet(1'b1);

      // EOP after three data bits.
      start_packet();
      send_sync(8'h80);
      for (int i = 0; i < 3; i++) emit_data_bit(1'($urandom_range(1, 0)));
      finish_packet(1'b1);

      // Reset after four data bits.
      start_packet();
      send_sync(8'h80);
      for (int i = 0; i < 4; i++) emit_data_bit(1'($urandom_range(1, 0)));
      in_pkt = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; #1;
      check("midbyte_rst_rcving", 32'(rcving), 32'd0);
      check("midbyte_rst_r_error", 32'(r_error), 32'd0);
      check("midbyte_rst_w_enable", 32'(w_enable), 32'd0);
      check("midbyte_rst_rx_data", 32'(rx_data), 32'd0);
      last_byte = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
      run_packet(0, 2);

      // Reset landing in the write cycle drops w_enable at once.
      start_packet();
      send_sync(8'h80);
      for (int i = 0; i < 7; i++) emit_data_bit(1'(8'h3C >> i));
      @(posedge clk); #1;
      en_sample = 1'b1; d_orig = 1'b0; eop = 1'b0;
      @(posedge clk); #1;
      en_sample = 1'b0;
      check("write_cycle_w_enable", 32'(w_enable), 32'd1);
      check("write_cycle_rx_data", 32'(rx_data), 32'h3C);
      in_pkt = 1'b0;
      rst = 1'b1; #1;
      check("async_rst_w_enable", 32'(w_enable), 32'd0);
      check("async_rst_rcving", 32'(rcving), 32'd0);
      check("async_rst_rx_data", 32'(rx_data), 32'd0);
      last_byte = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
      run_packet(0, 1);

      // Random packets of every kind.
      for (int p = 0; p < 30; p++) begin
         int kind;
         kind = $urandom_range(4, 0);
         run_packet(kind, $urandom_range(3, (kind == 4) ? 1 : 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
